// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM host master.
// Frame word layout is {opcode[1:0], payload[7:0]}, sent MSB first after a
// leading copy of the opcode MSB (the command bit). No ports; package only.
package spi_ram_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_W     = 8;
  localparam int WORD_W     = 10;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    TURN  = 3'd2,
    RECV  = 3'd3,
    GAP   = 3'd4
  } state_t;

  function automatic logic [WORD_W-1:0] frame_word(input logic [1:0]        op,
                                                   input logic [DATA_W-1:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Frame serializer: 10-bit load/shift register plus a 4-bit bit counter.
// The first cycle after load repeats word[9] as the command bit, then the
// ten word bits follow MSB first, giving an 11-cycle frame.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       capture word, restart bit counter at 0
//   shift_en   advance one bit (held high while the frame is on the wire)
//   word       frame word {opcode, payload}
//   mosi       current serial bit
//   last_bit   bit counter is on the final (11th) bit
module spi_frame_tx
  import spi_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word,
  output logic              mosi,
  output logic              last_bit
);

  logic [WORD_W-1:0] sreg;
  logic [3:0]        bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= word;
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 4'd1;
      // bit 0 (command bit) and bit 1 both present word[9]; shifting starts after bit 1
      if (bit_cnt != 4'd0) begin
        sreg <= {sreg[WORD_W-2:0], 1'b0};
      end
    end
  end

  assign mosi     = sreg[WORD_W-1];
  assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master that turns a single-cycle write/read request into the
// two-frame command sequence of the SPI slave + RAM subsystem, and returns
// read data sampled from MISO.
//
// state | meaning
// IDLE  | waiting for a host request, cmd_ready high
// SHIFT | SS_n low, 11-bit frame on MOSI
// TURN  | read only: SS_n low, MOSI 0, slave turnaround
// RECV  | read only: SS_n low, 8 MISO samples MSB first
// GAP   | SS_n high after every frame; phase picks next frame or IDLE
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           host request handshake
//   cmd_write, cmd_addr, cmd_wdata request fields, latched on accept
//   rsp_valid, rsp_rdata          one-cycle read response, data held
//   busy                          any state other than IDLE
//   SS_n, MOSI, MISO              SPI pins
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE   = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int TURN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int CNT_MAX = (GAP_CYCLES > TURN_CYCLES) ? GAP_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_next;
  logic              phase;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        rx_cnt;
  logic [DATA_W-1:0] rx_sreg;

  logic              accept;
  logic              turn_done;
  logic              gap_done;
  logic              recv_done;
  logic              rd_data_frame;
  logic              second_load;

  logic              tx_load;
  logic              tx_en;
  logic [WORD_W-1:0] tx_word;
  logic              tx_mosi;
  logic              tx_last;

  assign accept        = cmd_valid && (state == IDLE);
  assign turn_done     = (cnt == CNT_W'(TURN_CYCLES - 1));
  assign gap_done      = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign recv_done     = (rx_cnt == 4'(DATA_W - 1));
  assign rd_data_frame = phase && !wr_q;
  assign second_load   = (state == GAP) && gap_done && !phase;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (cmd_valid) state_next = SHIFT;
      SHIFT: begin
        if (tx_last) begin
          if (rd_data_frame) begin
            state_next = (TURN_CYCLES == 0) ? RECV : TURN;
          end else begin
            state_next = GAP;
          end
        end
      end
      TURN:  if (turn_done) state_next = RECV;
      RECV:  if (recv_done) state_next = GAP;
      GAP:   if (gap_done) state_next = phase ? IDLE : SHIFT;
      default: state_next = IDLE;
    endcase
  end

  // outputs and serializer control
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    SS_n      = !((state == SHIFT) || (state == TURN) || (state == RECV));
    MOSI      = (state == SHIFT) ? tx_mosi : 1'b0;
    tx_en     = (state == SHIFT);
    tx_load   = accept || second_load;
    // The first frame is loaded straight from the request, so the address
    // is held by the serializer itself rather than a separate register.
    if (state == IDLE) begin
      tx_word = frame_word(cmd_write ? OP_WR_ADDR : OP_RD_ADDR, DATA_W'(cmd_addr));
    end else if (wr_q) begin
      tx_word = frame_word(OP_WR_DATA, wdata_q);
    end else begin
      tx_word = frame_word(OP_RD_DATA, '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      rx_cnt    <= '0;
      rx_sreg   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wr_q    <= cmd_write;
        wdata_q <= cmd_wdata;
        phase   <= 1'b0;
      end else if (second_load) begin
        phase <= 1'b1;
      end

      if (((state == TURN) || (state == GAP)) && (state_next == state)) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      if ((state == RECV) && !recv_done) begin
        rx_cnt <= rx_cnt + 4'd1;
      end else begin
        rx_cnt <= '0;
      end

      if (state == RECV) begin
        rx_sreg <= {rx_sreg[DATA_W-2:0], MISO};
      end

      // response lands in the first GAP cycle after the last sample
      rsp_valid <= (state == RECV) && recv_done;
      if ((state == RECV) && recv_done) begin
        rsp_rdata <= {rx_sreg[DATA_W-2:0], MISO};
      end
    end
  end

  spi_frame_tx u_frame_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .shift_en (tx_en),
    .word     (tx_word),
    .mosi     (tx_mosi),
    .last_bit (tx_last)
  );

endmodule

// File: tb/tb_spi_ram_master.sv
module tb_spi_ram_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      cmd_valid;
  logic [1:0]      cmd_write;
  logic [1:0][7:0] cmd_addr;
  logic [1:0][7:0] cmd_wdata;
  logic [1:0]      miso = 2'b00;

  logic       ready0, busy0, rv0, ss0, mosi0;
  logic       ready1, busy1, rv1, ss1, mosi1;
  logic [7:0] rd0, rd1;

  spi_ram_master #(.ADDR_SIZE(8), .GAP_CYCLES(1), .TURN_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(ready0), .cmd_write(cmd_write[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rv0), .rsp_rdata(rd0), .busy(busy0),
    .SS_n(ss0), .MOSI(mosi0), .MISO(miso[0])
  );

  spi_ram_master #(.ADDR_SIZE(8), .GAP_CYCLES(3), .TURN_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(ready1), .cmd_write(cmd_write[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1),
    .SS_n(ss1), .MOSI(mosi1), .MISO(miso[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic get_ready(input int i); return (i == 0) ? ready0 : ready1; endfunction
  function automatic logic get_busy(input int i);  return (i == 0) ? busy0  : busy1;  endfunction
  function automatic logic get_rv(input int i);    return (i == 0) ? rv0    : rv1;    endfunction
  function automatic logic [7:0] get_rd(input int i); return (i == 0) ? rd0 : rd1;   endfunction
  function automatic int turn_of(input int i);     return (i == 0) ? 2 : 0;           endfunction

  function automatic logic [10:0] exp_frame(input logic [1:0] op, input logic [7:0] p);
    logic [9:0] w;
    w = {op, p};
    return {w[9], w};
  endfunction

  // ---------------- SPI slave + RAM model (one per DUT) ----------------
  typedef struct {
    logic [10:0] bits;
    int          len;
  } frame_t;

  frame_t      fq0[$], fq1[$];
  int          gq0[$], gq1[$];
  logic [7:0]  mem [2][256];
  int          k [2]      = '{0, 0};
  int          hi_run [2] = '{0, 0};
  bit          seen [2]   = '{1'b0, 1'b0};
  logic [10:0] cur [2];
  logic [7:0]  saddr [2];
  logic        mon_s, mon_m;
  int          mon_idx;
  frame_t      mon_fr;

  // Sampling mid-cycle sees what the slave would capture at the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mon_s = (i == 0) ? ss0 : ss1;
      mon_m = (i == 0) ? mosi0 : mosi1;
      if (!mon_s) begin
        if (k[i] == 0 && seen[i]) begin
          if (i == 0) gq0.push_back(hi_run[i]); else gq1.push_back(hi_run[i]);
        end
        if (k[i] < 11) cur[i][10 - k[i]] = mon_m;
        mon_idx = k[i] - 11 - turn_of(i);
        if (k[i] >= 11 && cur[i][9:8] == 2'b11 && mon_idx >= 0 && mon_idx < 8)
          miso[i] = mem[i][saddr[i]][7 - mon_idx];
        else
          miso[i] = 1'b0;
        k[i]++;
        hi_run[i] = 0;
      end else begin
        if (k[i] > 0) begin
          mon_fr.bits = cur[i];
          mon_fr.len  = k[i];
          if (i == 0) fq0.push_back(mon_fr); else fq1.push_back(mon_fr);
          if (k[i] >= 11) begin
            if (cur[i][9:8] == 2'b00 || cur[i][9:8] == 2'b10) saddr[i] = cur[i][7:0];
            if (cur[i][9:8] == 2'b01) mem[i][saddr[i]] = cur[i][7:0];
          end
          seen[i] = 1'b1;
        end
        k[i] = 0;
        hi_run[i]++;
        miso[i] = 1'b0;
      end
    end
  end

  // ---------------- host-side helpers ----------------
  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!get_ready(i) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_ready_timeout", 0, 1);
  endtask

  // Offsets are in accept-relative cycles: 1 = first cycle after the accept edge.
  task automatic run_op(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output int rsp_off, output int rdy_off);
    int acc;
    wait_ready(i);
    cmd_valid[i] = 1'b1;
    cmd_write[i] = wr;
    cmd_addr[i]  = a;
    cmd_wdata[i] = d;
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    rsp_off = -1;
    rdy_off = -1;
    rdata   = 8'h00;
    for (int n = 0; n < 100; n++) begin
      if (get_rv(i)) begin
        rsp_off = cyc - acc + 1;
        rdata   = get_rd(i);
      end
      if (get_ready(i)) begin
        rdy_off = cyc - acc + 1;
        break;
      end
      @(negedge clk);
    end
    if (rdy_off < 0) check("op_timeout", 0, 1);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_rsp;
    int         exp_rdy;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] rdata;
    int         rsp_off, rdy_off, acc1, acc2, n, rv_cnt, bad;
    frame_t     f;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00, -1, 25};
    vecs[1] = '{1'b1, 8'h10, 8'h5A, 8'h00, -1, 25};
    vecs[2] = '{1'b0, 8'h10, 8'h00, 8'h5A, 34, 35};
    vecs[3] = '{1'b0, 8'h3C, 8'h00, 8'hA5, 34, 35};
    vecs[4] = '{1'b1, 8'h10, 8'h96, 8'h00, -1, 25};
    vecs[5] = '{1'b0, 8'h10, 8'h00, 8'h96, 34, 35};
    vecs[6] = '{1'b0, 8'h77, 8'h00, 8'h00, 34, 35};
    vecs[7] = '{1'b1, 8'h00, 8'hFF, 8'h00, -1, 25};
    vecs[8] = '{1'b0, 8'h00, 8'h00, 8'hFF, 34, 35};

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;

    rst       = 1'b1;
    cmd_valid = 2'b00;
    cmd_write = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);

    check("reset_ss_n", int'(ss0), 1);
    check("reset_mosi", int'(mosi0), 0);
    check("reset_ready", int'(ready0), 1);
    check("reset_busy", int'(busy0), 0);
    check("reset_rsp_valid", int'(rv0), 0);
    check("reset_rdata", int'(rd0), 0);
    check("reset_ss_n_inst1", int'(ss1), 1);
    rst = 1'b0;

    // ---- table: single writes, loopback reads, overwrite, unwritten address
    for (int v = 0; v < 9; v++) begin
      fq0.delete();
      gq0.delete();
      run_op(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rdata, rsp_off, rdy_off);
      check($sformatf("vec%0d_ready_offset", v), rdy_off, vecs[v].exp_rdy);
      if (!vecs[v].wr) begin
        check($sformatf("vec%0d_rsp_offset", v), rsp_off, vecs[v].exp_rsp);
        check($sformatf("vec%0d_rdata", v), int'(rdata), int'(vecs[v].exp_rd));
      end
      check($sformatf("vec%0d_frame_count", v), fq0.size(), 2);
      if (fq0.size() == 2) begin
        check($sformatf("vec%0d_frame1_bits", v), int'(fq0[0].bits),
              int'(exp_frame(vecs[v].wr ? 2'b00 : 2'b10, vecs[v].addr)));
        check($sformatf("vec%0d_frame1_len", v), fq0[0].len, 11);
        check($sformatf("vec%0d_frame2_bits", v), int'(fq0[1].bits),
              int'(vecs[v].wr ? exp_frame(2'b01, vecs[v].wdata) : exp_frame(2'b11, 8'h00)));
        check($sformatf("vec%0d_frame2_len", v), fq0[1].len, vecs[v].wr ? 11 : 21);
      end
      if (gq0.size() >= 1) check($sformatf("vec%0d_mid_gap", v), gq0[gq0.size()-1], 1);
      else check($sformatf("vec%0d_mid_gap_missing", v), gq0.size(), 1);
    end

    // ---- reset mid-frame aborts a read
    wait_ready(0);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 8'h10;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_ss_low", int'(ss0), 0);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ss_n", int'(ss0), 1);
    check("midreset_mosi", int'(mosi0), 0);
    check("midreset_rsp_valid", int'(rv0), 0);
    check("midreset_ready", int'(ready0), 1);
    check("midreset_busy", int'(busy0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midreset_rdata_cleared", int'(rd0), 0);
    rv_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rv0 || !ss0) rv_cnt++;
    end
    check("post_reset_quiet", rv_cnt, 0);

    // ---- TURN_CYCLES=0, GAP_CYCLES=3 instance with MISO model
    mem[1][8'h42] = 8'hC3;
    fq1.delete(); gq1.delete();
    run_op(1, 1'b0, 8'h42, 8'h00, rdata, rsp_off, rdy_off);
    check("t0_read_rdata", int'(rdata), 8'hC3);
    check("t0_read_rsp_offset", rsp_off, 34);
    check("t0_read_ready_offset", rdy_off, 37);
    if (gq1.size() >= 1) check("t0_mid_gap", gq1[gq1.size()-1], 3);
    else check("t0_mid_gap_missing", gq1.size(), 1);
    if (fq1.size() == 2) check("t0_rd_frame_len", fq1[1].len, 19);
    else check("t0_frame_count", fq1.size(), 2);
    run_op(1, 1'b1, 8'h05, 8'h3E, rdata, rsp_off, rdy_off);
    check("t0_write_ready_offset", rdy_off, 29);
    run_op(1, 1'b0, 8'h05, 8'h00, rdata, rsp_off, rdy_off);
    check("t0_readback", int'(rdata), 8'h3E);

    // ---- back-to-back with cmd_valid held high
    gq0.delete();
    wait_ready(0);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 8'h01; cmd_wdata[0] = 8'hFF;
    acc1 = cyc + 1;
    @(negedge clk);
    cmd_write[0] = 1'b0; cmd_wdata[0] = 8'h00;
    n = 0;
    while (!ready0 && n < 100) begin @(negedge clk); n++; end
    check("b2b_first_idle_offset", cyc - acc1 + 1, 25);
    acc2 = cyc + 1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check("b2b_second_accepted", int'(busy0), 1);
    rsp_off = -1; rdata = 8'h00; n = 0;
    while (!ready0 && n < 100) begin
      if (rv0) begin rsp_off = cyc - acc2 + 1; rdata = rd0; end
      @(negedge clk);
      n++;
    end
    check("b2b_rsp_offset", rsp_off, 34);
    check("b2b_rdata", int'(rdata), 8'hFF);
    check("b2b_gap_count", gq0.size(), 4);
    if (gq0.size() == 4) begin
      check("b2b_gap_between_ops", gq0[2], 2);
      check("b2b_gap_mid_read", gq0[3], 1);
    end

    // ---- busy immunity: inputs churn while a write is in flight
    fq0.delete();
    wait_ready(0);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 8'h22; cmd_wdata[0] = 8'h77;
    acc1 = cyc + 1;
    @(negedge clk);
    bad = 0; n = 0;
    while (!ready0 && n < 100) begin
      if (!busy0) bad++;
      cmd_valid[0] = 1'($urandom);
      cmd_write[0] = 1'($urandom);
      cmd_addr[0]  = 8'($urandom);
      cmd_wdata[0] = 8'($urandom);
      @(negedge clk);
      n++;
    end
    cmd_valid[0] = 1'b0;
    check("busy_consistency", bad, 0);
    check("busy_ready_offset", cyc - acc1 + 1, 25);
    check("busy_frame_count", fq0.size(), 2);
    if (fq0.size() == 2) begin
      f = fq0[0];
      check("busy_frame1_bits", int'(f.bits), int'(exp_frame(2'b00, 8'h22)));
      f = fq0[1];
      check("busy_frame2_bits", int'(f.bits), int'(exp_frame(2'b01, 8'h77)));
    end
    run_op(0, 1'b0, 8'h22, 8'h00, rdata, rsp_off, rdy_off);
    check("busy_readback", int'(rdata), 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
